stopwatch_bcd_lap: RTL and testbench

//  Parametrised stopwatch with start/stop, lap freeze and clear, counting M..M:S1S0.F in BCD.
//  On-chip tick prescaler; no external divided clock. One Clk domain.

---
 rtl/stopwatch_pkg.sv | 32 +++
 rtl/bcd_digit_counter.sv | 37 +++
 rtl/stopwatch_bcd_lap.sv | 145 ++++++++++++++
 tb/tb_stopwatch_bcd_lap.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// ============================================================================
// stopwatch_pkg : state encoding, BCD width and 7-segment decode for the stopwatch
// Rev 1.0
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    PAUSE    = 2'd2,
    LAP_HOLD = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Segment order {g,f,e,d,c,b,a}; entry 0 is the rightmost slice.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg7(input logic [BCD_W-1:0] d);
    seg7 = (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_counter.sv
// ============================================================================
// bcd_digit_counter : one modulo-N BCD digit with carry-out for chaining
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  localparam logic [BCD_W-1:0] C_LAST = BCD_W'(MODULUS - 1);

  logic [BCD_W-1:0] r_q;

  always_ff @(posedge Clk) begin
    if (reset || clr) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= (r_q == C_LAST) ? '0 : r_q + 4'd1;
    end
  end

  assign q     = r_q;
  assign carry = inc && (r_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/stopwatch_bcd_lap.sv
// ============================================================================
// stopwatch_bcd_lap : BCD stopwatch M..M:S1S0.F with run/pause, lap freeze, clear
// Optional: STOPWATCH_SATURATE_EN holds at max time instead of wrapping. Rev 1.0
// ============================================================================
`default_nettype none

module stopwatch_bcd_lap
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 10,
  parameter int MIN_DIGITS = 1
) (
  input  logic                              Clk,
  input  logic                              reset,
  input  logic                              start_stop,
  input  logic                              lap,
  input  logic                              clear,
  output logic                              running,
  output logic                              lap_active,
  output logic                              ovf,
  output logic [BCD_W*(3+MIN_DIGITS)-1:0]   bcd,
  output logic [6:0]                        F,
  output logic [6:0]                        S0,
  output logic [6:0]                        S1,
  output logic [7*MIN_DIGITS-1:0]           M
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int ND  = 3 + MIN_DIGITS;
  localparam int DW  = BCD_W * ND;

  localparam logic [PW-1:0] C_PRESC_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] C_MAX_TIME   = {{MIN_DIGITS{4'h9}}, 12'h599};

  state_t           r_state, w_next;
  logic [PW-1:0]    r_presc;
  logic [DW-1:0]    r_snap;
  logic             r_ovf;
  logic [DW-1:0]    w_live, w_disp;
  logic [ND-1:0]    w_inc, w_carry;
  logic             w_counting, w_tick, w_capture, w_at_max;

  always_ff @(posedge Clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = IDLE;
    end else if (start_stop) begin
      case (r_state)
        IDLE, PAUSE:   w_next = RUN;
        RUN, LAP_HOLD: w_next = PAUSE;
        default:       w_next = IDLE;
      endcase
    end else if (lap) begin
      case (r_state)
        RUN:      w_next = LAP_HOLD;
        LAP_HOLD: w_next = RUN;
        default:  w_next = r_state;
      endcase
    end
  end

  always_comb begin
    running    = (r_state == RUN) || (r_state == LAP_HOLD);
    lap_active = (r_state == LAP_HOLD);
    w_counting = running;
    w_capture  = (r_state == RUN) && (w_next == LAP_HOLD);
  end

  // Prescaler keeps its phase across a pause so resuming does not lose time.
  assign w_tick = w_counting && (r_presc == C_PRESC_LAST);

  always_ff @(posedge Clk) begin
    if (reset || clear) begin
      r_presc <= '0;
    end else if (w_counting) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end else if (r_state == IDLE) begin
      r_presc <= '0;
    end
  end

  assign w_at_max = (w_live == C_MAX_TIME);

`ifdef STOPWATCH_SATURATE_EN
  assign w_inc[0] = w_tick && !w_at_max;
`else
  assign w_inc[0] = w_tick;
`endif

  generate
    for (genvar gi = 0; gi < ND; gi++) begin : g_digit
      localparam int C_MOD = (gi == 2) ? 6 : 10;
      bcd_digit_counter #(.MODULUS(C_MOD)) u_digit (
        .Clk   (Clk),
        .reset (reset),
        .clr   (clear),
        .inc   (w_inc[gi]),
        .q     (w_live[gi*BCD_W +: BCD_W]),
        .carry (w_carry[gi])
      );
      if (gi < ND - 1) begin : g_chain
        assign w_inc[gi+1] = w_carry[gi];
      end
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (reset || clear) begin
      r_ovf <= 1'b0;
    end else if (w_carry[ND-1] || (w_tick && w_at_max)) begin
      r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset || clear) begin
      r_snap <= '0;
    end else if (w_capture) begin
      r_snap <= w_live;
    end
  end

  assign ovf    = r_ovf;
  assign w_disp = (r_state == LAP_HOLD) ? r_snap : w_live;
  assign bcd    = w_disp;
  assign F      = seg7(w_disp[3:0]);
  assign S0     = seg7(w_disp[7:4]);
  assign S1     = seg7(w_disp[11:8]);

  generate
    for (genvar gm = 0; gm < MIN_DIGITS; gm++) begin : g_mseg
      assign M[gm*7 +: 7] = seg7(w_disp[(3+gm)*BCD_W +: BCD_W]);
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_bcd_lap.sv
// ============================================================================
// tb_stopwatch_bcd_lap : directed self-checking bench, CLK_HZ=100 TICK_HZ=10 (DIV=10)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_bcd_lap;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_stop = 1'b0;
  logic        lap = 1'b0;
  logic        clear = 1'b0;
  logic        running, lap_active, ovf;
  logic [15:0] bcd;
  logic [6:0]  F, S0, S1, M;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  stopwatch_bcd_lap #(
    .CLK_HZ     (100),
    .TICK_HZ    (10),
    .MIN_DIGITS (1)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .running    (running),
    .lap_active (lap_active),
    .ovf        (ovf),
    .bcd        (bcd),
    .F          (F),
    .S0         (S0),
    .S1         (S1),
    .M          (M)
  );

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One-cycle pulse covering exactly one rising edge; returns at the next negedge.
  task automatic drive(input logic ss, input logic lp, input logic cl);
    start_stop = ss; lap = lp; clear = cl;
    @(negedge Clk);
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h want %h", bcd, 16'h0000); end
    checks++; if ({F, S0, S1, M} !== {4{7'b0111111}}) begin errors++; $display("FAIL reset_seg: got %h want %h", {F, S0, S1, M}, {4{7'b0111111}}); end
    checks++; if ({running, lap_active, ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {running, lap_active, ovf}); end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_run();
    drive(0, 0, 1);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL run_idle_running: got %b want 0", running); end
    drive(1, 0, 0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running: got %b want 1", running); end
    step(9);
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL run_pre_tick: got %h want %h", bcd, 16'h0000); end
    step(1);
    checks++; if (bcd !== 16'h0001) begin errors++; $display("FAIL run_first_tick: got %h want %h", bcd, 16'h0001); end
    step(240);
    checks++; if (bcd !== 16'h0025) begin errors++; $display("FAIL run_250_bcd: got %h want %h", bcd, 16'h0025); end
    checks++; if ({F, S0} !== {7'h6D, 7'h5B}) begin errors++; $display("FAIL run_250_seg: got %h want %h", {F, S0}, {7'h6D, 7'h5B}); end
  endtask

  task automatic test_carry();
    drive(0, 0, 1);
    drive(1, 0, 0);
    step(5990);
    checks++; if (bcd !== 16'h0599) begin errors++; $display("FAIL carry_0599: got %h want %h", bcd, 16'h0599); end
    step(10);
    checks++; if (bcd !== 16'h1000) begin errors++; $display("FAIL carry_1000: got %h want %h", bcd, 16'h1000); end
    checks++; if ({M, S1, S0, F} !== {7'h06, 7'h3F, 7'h3F, 7'h3F}) begin errors++; $display("FAIL carry_seg: got %h want %h", {M, S1, S0, F}, {7'h06, 7'h3F, 7'h3F, 7'h3F}); end
  endtask

  task automatic test_pause();
    drive(0, 0, 1);
    drive(1, 0, 0);
    step(133);
    drive(1, 0, 0);
    checks++; if ({running, bcd} !== {1'b0, 16'h0013}) begin errors++; $display("FAIL pause_enter: got %h want %h", {running, bcd}, {1'b0, 16'h0013}); end
    drive(0, 1, 0);
    step(36);
    checks++; if ({lap_active, bcd} !== {1'b0, 16'h0013}) begin errors++; $display("FAIL pause_hold: got %h want %h", {lap_active, bcd}, {1'b0, 16'h0013}); end
    drive(1, 0, 0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_resume: got %b want 1", running); end
    step(5);
    checks++; if (bcd !== 16'h0013) begin errors++; $display("FAIL pause_pre_tick: got %h want %h", bcd, 16'h0013); end
    step(1);
    checks++; if (bcd !== 16'h0014) begin errors++; $display("FAIL pause_tick6: got %h want %h", bcd, 16'h0014); end
  endtask

  task automatic test_lap();
    drive(0, 0, 1);
    drive(1, 0, 0);
    step(300);
    drive(0, 1, 0);
    checks++; if ({running, lap_active, bcd} !== {2'b11, 16'h0030}) begin errors++; $display("FAIL lap_enter: got %h want %h", {running, lap_active, bcd}, {2'b11, 16'h0030}); end
    step(200);
    checks++; if ({lap_active, bcd} !== {1'b1, 16'h0030}) begin errors++; $display("FAIL lap_frozen: got %h want %h", {lap_active, bcd}, {1'b1, 16'h0030}); end
    checks++; if (S0 !== 7'h4F) begin errors++; $display("FAIL lap_seg: got %h want %h", S0, 7'h4F); end
    drive(0, 1, 0);
    checks++; if ({lap_active, bcd} !== {1'b0, 16'h0050}) begin errors++; $display("FAIL lap_release: got %h want %h", {lap_active, bcd}, {1'b0, 16'h0050}); end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 1);
    drive(1, 0, 0);
    step(20);
    drive(1, 1, 0);
    checks++; if ({running, lap_active, bcd} !== {2'b00, 16'h0002}) begin errors++; $display("FAIL b2b_ss_over_lap: got %h want %h", {running, lap_active, bcd}, {2'b00, 16'h0002}); end
  endtask

  task automatic test_wrap();
    drive(0, 0, 1);
    drive(1, 0, 0);
    step(59990);
    checks++; if ({ovf, bcd} !== {1'b0, 16'h9599}) begin errors++; $display("FAIL wrap_max: got %h want %h", {ovf, bcd}, {1'b0, 16'h9599}); end
    step(10);
`ifdef STOPWATCH_SATURATE_EN
    checks++; if ({running, ovf, bcd} !== {2'b11, 16'h9599}) begin errors++; $display("FAIL sat_hold: got %h want %h", {running, ovf, bcd}, {2'b11, 16'h9599}); end
    step(10);
    checks++; if ({ovf, bcd} !== {1'b1, 16'h9599}) begin errors++; $display("FAIL sat_sticky: got %h want %h", {ovf, bcd}, {1'b1, 16'h9599}); end
`else
    checks++; if ({running, ovf, bcd} !== {2'b11, 16'h0000}) begin errors++; $display("FAIL wrap_zero: got %h want %h", {running, ovf, bcd}, {2'b11, 16'h0000}); end
    step(10);
    checks++; if ({ovf, bcd} !== {1'b1, 16'h0001}) begin errors++; $display("FAIL wrap_sticky: got %h want %h", {ovf, bcd}, {1'b1, 16'h0001}); end
`endif
  endtask

  task automatic test_clear_priority();
    drive(1, 0, 1);
    checks++; if ({running, ovf, bcd} !== {2'b00, 16'h0000}) begin errors++; $display("FAIL clr_wins: got %h want %h", {running, ovf, bcd}, {2'b00, 16'h0000}); end
    step(20);
    checks++; if ({running, bcd} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL clr_idle_hold: got %h want %h", {running, bcd}, {1'b0, 16'h0000}); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_carry();
    test_pause();
    test_lap();
    test_back_to_back();
    test_wrap();
    test_clear_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
